rr_mux4_arbiter: RTL



---
 rtl/rr_arb_pkg.sv | 38 +++
 rtl/mux4_bus.sv | 25 ++
 rtl/rr_mux4_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter and its output mux.
// Holds the requester count, the select width, the arbiter state type and
// the rotating-priority helpers used by the arbiter core.
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Winner search starts just after the last granted index and wraps around.
  // The last index visited is the previous holder itself. The loop runs from
  // the farthest candidate to the nearest one, so the nearest requesting
  // index overwrites the others. When no bit of r is set, p is returned.
  // Callers check for that case before they use the result.
  function automatic logic [SEL_W-1:0] rr_winner(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   p);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] w;
    w = p;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = p + k[SEL_W-1:0];
      if (r[idx]) begin
        w = idx;
      end
    end
    return w;
  endfunction

  // Converts a select index to the matching one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux4_bus.sv
// Plain 4:1 word multiplexer. The select input chooses one DATA_W-wide slice
// of the packed input bus. Requester i sits at bits [i*DATA_W +: DATA_W].
module mux4_bus
  import rr_arb_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         data_out
);

  // Route the selected requester's word to the output.
  always_comb begin
    data_out = '0;
    case (sel)
      2'd0:    data_out = data_in[0*DATA_W +: DATA_W];
      2'd1:    data_out = data_in[1*DATA_W +: DATA_W];
      2'd2:    data_out = data_in[2*DATA_W +: DATA_W];
      2'd3:    data_out = data_in[3*DATA_W +: DATA_W];
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that shares one 4:1 data path among four requesters.
// The grant, select and busy outputs are registered. data_out is the
// combinational mux output, forced to zero while no grant is active.
// Optional macro RR_HOLD_TIMEOUT_EN limits one grant to MAX_HOLD cycles when
// other requesters are waiting. Without it, a grant lasts until the holder
// drops its request.
module rr_mux4_arbiter
  import rr_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy,
  output logic [DATA_W-1:0]         data_out
);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     ptr, ptr_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic                 busy_nxt;
  logic [DATA_W-1:0]    mux_out;

`ifdef RR_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0]            hold_cnt, hold_cnt_nxt;
  logic [NUM_REQ-1:0]    others;
  assign others = req & ~gnt;
`endif

  // Next-state decision. A new grant always moves gnt, sel and ptr together,
  // so the pointer remembers who was served last. This holds even after the
  // arbiter returns to idle.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
`ifdef RR_HOLD_TIMEOUT_EN
    hold_cnt_nxt = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = rr_winner(req, ptr);
          ptr_nxt   = rr_winner(req, ptr);
          gnt_nxt   = sel_to_onehot(rr_winner(req, ptr));
          busy_nxt  = 1'b1;
`ifdef RR_HOLD_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      GRANT: begin
        if (req[sel]) begin
`ifdef RR_HOLD_TIMEOUT_EN
          // When the hold limit is reached, a waiting requester takes over.
          // If nobody else is waiting, the holder keeps the grant and the
          // counter starts again.
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt_nxt = '0;
            if (|others) begin
              sel_nxt = rr_winner(others, sel);
              ptr_nxt = rr_winner(others, sel);
              gnt_nxt = sel_to_onehot(rr_winner(others, sel));
            end
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
          end
`else
          // Without the timeout, the holder keeps the grant for as long as
          // it requests.
          state_nxt = GRANT;
`endif
        end else if (|req) begin
          // On release, the next winner is chosen in the same cycle, so
          // there is no idle cycle between grants.
          sel_nxt = rr_winner(req, sel);
          ptr_nxt = rr_winner(req, sel);
          gnt_nxt = sel_to_onehot(rr_winner(req, sel));
`ifdef RR_HOLD_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
        end else begin
          state_nxt = IDLE;
          ptr_nxt   = sel;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Register the arbiter state and outputs. Reset puts the pointer at 3, so
  // requester 0 has top priority for the first grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd3;
      sel   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
    end
  end

`ifdef RR_HOLD_TIMEOUT_EN
  // Count the consecutive cycles of the current grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
    end
  end
`endif

  mux4_bus #(
    .DATA_W(DATA_W)
  ) u_mux (
    .data_in (data_in),
    .sel     (sel),
    .data_out(mux_out)
  );

  assign data_out = busy ? mux_out : '0;

endmodule
